// File: rtl/i2s_feed_ctrl.sv
// Stereo sample feeder for the i2s serializer: two requesters share a small
// FIFO through a round-robin arbiter, drained one entry per sample strobe.
module i2s_feed_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_clk_en,
    input  logic                          mute,
    input  logic                          req0_valid,
    input  logic signed [DATA_WIDTH-1:0]  req0_left,
    input  logic signed [DATA_WIDTH-1:0]  req0_right,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic signed [DATA_WIDTH-1:0]  req1_left,
    input  logic signed [DATA_WIDTH-1:0]  req1_right,
    output logic                          req1_ready,
    output logic signed [DATA_WIDTH-1:0]  left_channel,
    output logic signed [DATA_WIDTH-1:0]  right_channel,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    prio;
    logic                    ready_en;
    logic                    space;
    logic                    push0;
    logic                    push1;
    logic                    push;
    logic                    pop;
    logic                    empty;
    logic [2*DATA_WIDTH-1:0] push_data;
    logic [2*DATA_WIDTH-1:0] head;

    // The favoured requester is ready whenever there is room; the other one
    // only when the favoured requester is idle, so at most one write per cycle.
    always_comb begin
        space      = ready_en && (fifo_level < LEVEL_FULL);
        req0_ready = space && (!prio || !req1_valid);
        req1_ready = space && (prio || !req0_valid);
        push0      = req0_valid && req0_ready;
        push1      = req1_valid && req1_ready;
        push       = push0 || push1;
        push_data  = push1 ? {req1_left, req1_right} : {req0_left, req0_right};
        empty      = (fifo_level == '0);
        pop        = sample_clk_en && !empty;
        head       = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en       <= 1'b0;
            prio           <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            left_channel   <= '0;
            right_channel  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                prio   <= push0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // A push landing on an empty FIFO in a strobe cycle is too late for
            // this period: it counts as an underrun and stays queued.
            underrun <= sample_clk_en && empty;
            if (sample_clk_en && empty) begin
                underrun_count <= sat_inc(underrun_count);
            end
            if (sample_clk_en) begin
                if (mute) begin
                    left_channel  <= '0;
                    right_channel <= '0;
                end else if (!empty) begin
                    left_channel  <= $signed(head[2*DATA_WIDTH-1:DATA_WIDTH]);
                    right_channel <= $signed(head[DATA_WIDTH-1:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_feed_ctrl.sv
// Bench for i2s_feed_ctrl: directed scenarios plus a random phase, all checked
// against a queue-based reference model.
module tb_i2s_feed_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_clk_en;
    logic          mute;
    logic          req0_valid;
    logic [DW-1:0] req0_left;
    logic [DW-1:0] req0_right;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_left;
    logic [DW-1:0] req1_right;
    logic          req1_ready;
    logic [DW-1:0] left_channel;
    logic [DW-1:0] right_channel;
    logic          underrun;
    logic [15:0]   underrun_count;
    logic [2:0]    fifo_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_feed_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_clk_en  (sample_clk_en),
        .mute           (mute),
        .req0_valid     (req0_valid),
        .req0_left      (req0_left),
        .req0_right     (req0_right),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_left      (req1_left),
        .req1_right     (req1_right),
        .req1_ready     (req1_ready),
        .left_channel   (left_channel),
        .right_channel  (right_channel),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    // Reference model: queue of stereo pairs plus expected output registers.
    logic [2*DW-1:0] q[$];
    logic [DW-1:0]   exp_l;
    logic [DW-1:0]   exp_r;
    logic            exp_ur;
    logic [15:0]     exp_cnt;
    bit              favour1;
    bit              started;
    bit              won0;
    bit              won1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_l   = '0;
        exp_r   = '0;
        exp_ur  = 1'b0;
        exp_cnt = '0;
        favour1 = 1'b0;
        started = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_left"},  left_channel, 0);
        check({tag, "_right"}, right_channel, 0);
        check({tag, "_ur"},    underrun, 0);
        check({tag, "_cnt"},   underrun_count, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_rdy0"},  req0_ready, 0);
        check({tag, "_rdy1"},  req1_ready, 0);
    endtask

    // Raises reset mid-cycle (asynchronous effect checked at once), holds it
    // across one edge, releases it just after that edge.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        reset = 1'b0;
    endtask

    // One clock cycle: check ready/level before the edge, advance the model
    // across the edge, then check the registered outputs.
    task automatic tick();
        bit              space;
        bit              r0;
        bit              r1;
        bit              was_empty;
        logic [2*DW-1:0] head;
        #1;
        space = started && (q.size() < DEPTH);
        r0    = space && (!favour1 || !req1_valid);
        r1    = space && (favour1 || !req0_valid);
        check("req0_ready", req0_ready, r0);
        check("req1_ready", req1_ready, r1);
        check("level_pre", fifo_level, q.size());
        won0      = req0_valid && r0;
        won1      = req1_valid && r1;
        was_empty = (q.size() == 0);
        @(posedge clk);
        if (sample_clk_en) begin
            if (!was_empty) begin
                head  = q.pop_front();
                exp_l = head[2*DW-1:DW];
                exp_r = head[DW-1:0];
            end else if (exp_cnt != 16'hFFFF) begin
                exp_cnt = exp_cnt + 16'd1;
            end
            if (mute) begin
                exp_l = '0;
                exp_r = '0;
            end
        end
        exp_ur = sample_clk_en && was_empty;
        if (won0) begin
            q.push_back({req0_left, req0_right});
            favour1 = 1'b1;
        end else if (won1) begin
            q.push_back({req1_left, req1_right});
            favour1 = 1'b0;
        end
        started = 1'b1;
        #1;
        check("left", left_channel, exp_l);
        check("right", right_channel, exp_r);
        check("underrun", underrun, exp_ur);
        check("ur_count", underrun_count, exp_cnt);
        check("level_post", fifo_level, q.size());
    endtask

    // Pushes `count` entries from one requester, data base+n, until accepted.
    task automatic push_entries(input bit use1, input int count,
                                input logic [15:0] base_l, input logic [15:0] base_r);
        logic [15:0] n;
        int          guard;
        n     = '0;
        guard = 0;
        while (int'(n) < count && guard < 40) begin
            if (use1) begin
                req1_valid = 1'b1;
                req1_left  = base_l + n;
                req1_right = base_r + n;
            end else begin
                req0_valid = 1'b1;
                req0_left  = base_l + n;
                req0_right = base_r + n;
            end
            tick();
            if (won0 || won1) n = n + 16'd1;
            guard++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("push_done", n, count);
    endtask

    task automatic strobe(input bit m);
        sample_clk_en = 1'b1;
        mute          = m;
        tick();
        sample_clk_en = 1'b0;
    endtask

    initial begin
        logic [15:0] n0;
        logic [15:0] n1;
        int          guard;
        logic [15:0] seq030 [4];

        reset         = 1'b1;
        sample_clk_en = 1'b0;
        mute          = 1'b0;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        req0_left     = '0;
        req0_right    = '0;
        req1_left     = '0;
        req1_right    = '0;
        model_reset();
        apply_reset();

        // In-order playback from requester 0
        push_entries(1'b0, 4, 16'h0001, 16'h8001);
        check("s029_level_full", fifo_level, 4);
        for (int k = 0; k < 4; k++) begin
            strobe(1'b0);
            check("s029_left", left_channel, 16'h0001 + k);
            check("s029_right", right_channel, 16'h8001 + k);
            check("s029_no_ur", underrun, 0);
            tick();
        end
        check("s029_level_empty", fifo_level, 0);
        check("s029_cnt", underrun_count, 0);

        // Both requesters always valid: alternation, req0 first
        apply_reset();
        n0 = '0;
        n1 = '0;
        guard = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        while (q.size() < DEPTH && guard < 20) begin
            req0_left  = 16'h1000 + n0;
            req0_right = 16'h1100 + n0;
            req1_left  = 16'h2000 + n1;
            req1_right = 16'h2100 + n1;
            tick();
            if (won0) n0 = n0 + 16'd1;
            if (won1) n1 = n1 + 16'd1;
            guard++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        seq030 = '{16'h1000, 16'h2000, 16'h1001, 16'h2001};
        for (int k = 0; k < 4; k++) begin
            strobe(1'b0);
            check("s030_order", left_channel, seq030[k]);
        end

        // Underruns hold the last sample
        apply_reset();
        push_entries(1'b0, 1, 16'h1234, 16'h1234);
        strobe(1'b0);
        check("s031_loaded", left_channel, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            strobe(1'b0);
            check("s031_ur_pulse", underrun, 1);
            check("s031_hold", left_channel, 16'h1234);
            tick();
            check("s031_ur_clear", underrun, 0);
        end
        check("s031_cnt", underrun_count, 3);

        // Full FIFO back-pressure and refill
        apply_reset();
        push_entries(1'b1, 4, 16'h3000, 16'h3100);
        req1_valid = 1'b1;
        req1_left  = 16'h3ABC;
        req1_right = 16'h3DEF;
        #1;
        check("s032_full_ready", req1_ready, 0);
        tick();
        strobe(1'b0);
        check("s032_level_after_pop", fifo_level, 3);
        check("s032_ready_again", req1_ready, 1);
        tick();
        check("s032_refilled", fifo_level, 4);
        req1_valid = 1'b0;

        // Mute drains the FIFO with zero output
        apply_reset();
        push_entries(1'b0, 2, 16'h0A0A, 16'h0B0B);
        for (int k = 0; k < 2; k++) begin
            strobe(1'b1);
            check("s033_mute_left", left_channel, 0);
            check("s033_mute_right", right_channel, 0);
        end
        mute = 1'b0;
        check("s033_level", fifo_level, 0);
        push_entries(1'b1, 1, 16'h5555, 16'h6666);
        strobe(1'b0);
        check("s033_unmuted", left_channel, 16'h5555);
        check("s033_unmuted_r", right_channel, 16'h6666);

        // Reset mid-operation
        apply_reset();
        for (int k = 0; k < 5; k++) strobe(1'b0);
        push_entries(1'b0, 3, 16'h7000, 16'h7100);
        check("s034_pre_cnt", underrun_count, 5);
        check("s034_pre_level", fifo_level, 3);
        apply_reset();
        strobe(1'b0);
        check("s034_post_ur", underrun, 1);
        check("s034_post_cnt", underrun_count, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            req0_valid    = ($urandom_range(0, 1) == 1);
            req1_valid    = ($urandom_range(0, 1) == 1);
            req0_left     = 16'($urandom);
            req0_right    = 16'($urandom);
            req1_left     = 16'($urandom);
            req1_right    = 16'($urandom);
            sample_clk_en = ($urandom_range(0, 3) == 0);
            mute          = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_feed_ctrl.md
I2S_FEED_CTRL -- requirements
Module: i2s_feed_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default DAC_OUTPUT_WIDTH (16): bits per channel sample.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: stereo entries buffered; power of 2, >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sample_clk_en, input, 1 bit: one-cycle strobe per output sample period, from clk_div.
REQ-006 The block SHALL have port mute, input, 1 bit: force zero output samples while high.
REQ-007 The block SHALL have ports req0_valid (input, 1), req0_left (input, DATA_WIDTH), req0_right (input, DATA_WIDTH) and req0_ready (output, 1): requester 0 (synth) stereo sample handshake.
REQ-008 The block SHALL have ports req1_valid, req1_left, req1_right and req1_ready, with the same directions and widths as requester 0: requester 1 (host PCM / test tone).
REQ-009 The block SHALL have ports left_channel and right_channel, each output, DATA_WIDTH bits: registered samples to the i2s serializer.
REQ-010 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a sample period finds the FIFO empty.
REQ-011 The block SHALL have port underrun_count, output, 16 bits: saturating count of underruns.
REQ-012 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current number of FIFO entries.

Function
REQ-013 A write SHALL occur on a cycle where reqN_valid && reqN_ready; at most one write per cycle.
REQ-014 reqN_ready SHALL be asserted only for the requester selected by the arbiter and only when fifo_level < FIFO_DEPTH (registered level); it SHALL NOT depend on that requester's own valid.
REQ-015 Arbitration SHALL be round-robin via a 1-bit priority pointer: the pointer-favoured requester is selected if valid, else the other requester.
REQ-016 The pointer SHALL move to the non-winning requester after each write and SHALL be unchanged otherwise.
REQ-017 Each write SHALL push {left,right} of the winner as one FIFO entry; the FIFO SHALL be a circular buffer with wrap-around read and write pointers.
REQ-018 On sample_clk_en with fifo_level > 0, the head entry SHALL be popped and loaded into left_channel/right_channel, visible the cycle after the strobe.
REQ-019 On sample_clk_en with fifo_level == 0, left_channel/right_channel SHALL hold their previous values, underrun SHALL pulse high for exactly the next cycle, and underrun_count SHALL increment, saturating at 16'hFFFF.
REQ-020 On sample_clk_en with mute high, the pop/underrun behaviour SHALL be unchanged, but left_channel/right_channel SHALL load 0.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-022 A push when full SHALL be impossible, because ready is low.
REQ-023 A push into an empty FIFO on the same cycle as sample_clk_en SHALL count as an underrun; the pushed entry SHALL remain queued.
REQ-024 Outputs SHALL change only on sample_clk_en cycles, apart from underrun deassertion and the ready/level updates.
REQ-025 Data pushed SHALL be popped in exactly push order; no entry is lost or duplicated.

Reset
REQ-026 While reset is high, left_channel, right_channel, underrun, underrun_count and fifo_level SHALL be 0, both ready outputs 0, the FIFO empty and the pointer favouring requester 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-028 Ready SHALL first assert on the first clk edge after reset deasserts.

Verification
REQ-029 Req0 only, pushes 0x0001..0x0004 (left) / 0x8001..0x8004 (right), then four strobes -> outputs step through the pairs in order; fifo_level goes 4->0; no underrun.
REQ-030 Both requesters continuously valid, req0 data 0x1000+n, req1 data 0x2000+n -> FIFO contents alternate req0, req1, req0, ...; the first grant goes to req0.
REQ-031 Empty FIFO, 3 strobes with outputs at 0x1234 -> outputs stay 0x1234; three one-cycle underrun pulses; underrun_count == 3.
REQ-032 FIFO full (4 entries), requester valid -> ready low; one strobe -> ready high the next cycle, level 4->3, then refilled to 4.
REQ-033 Mute high across 2 strobes with 2 queued entries -> outputs 0; level 2->0; after unmute, the next pushed sample appears on the next strobe.
REQ-034 Reset asserted with 3 entries queued and underrun_count 5 -> all outputs 0 the same cycle; after release, the first strobe yields an underrun with count 1.
